// File: rtl/sysid_pkg.sv
// Shared constants for the system-identification register bank: word map,
// control/status bit positions and the legal parameter ranges.
package sysid_pkg;

  localparam logic [3:0] ADDR_ID        = 4'd0;
  localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
  localparam logic [3:0] ADDR_UPTIME_LO = 4'd2;
  localparam logic [3:0] ADDR_UPTIME_HI = 4'd3;
  localparam logic [3:0] ADDR_CTRL      = 4'd4;
  localparam logic [3:0] ADDR_STATUS    = 4'd5;
  localparam logic [3:0] ADDR_SCRATCH0  = 4'd8;

  localparam int CTRL_FREEZE_BIT    = 0;
  localparam int CTRL_CLEAR_BIT     = 1;
  localparam int STATUS_WRAPPED_BIT = 0;

  localparam int CNT_W_MIN       = 33;
  localparam int CNT_W_MAX       = 64;
  localparam int NUM_SCRATCH_MIN = 0;
  localparam int NUM_SCRATCH_MAX = 8;

endpackage

// File: rtl/sysid_if.sv
// Avalon-MM slave bus (fixed read latency 1, no waitrequest) for the sysid block.
interface sysid_if;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_uptime_counter.sv
// Free-running uptime counter with hold and synchronous clear; wrap_pulse marks
// the edge on which the counter rolls from all-ones to zero.
module sysid_uptime_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             freeze,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             wrap_pulse
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (!freeze) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Clear beats increment, so a clear on the all-ones cycle is not a wrap.
  assign wrap_pulse = !clear && !freeze && (count_q == '1);
  assign count      = count_q;

endmodule

// File: rtl/sysid_info_regs.sv
// System-ID / build-info register bank: address decode, uptime shadow,
// control/status bits, scratch array and the one-cycle read pipeline.
module sysid_info_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID   = 32'h6069_9AF2,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter int          CNT_W       = 64,
  parameter int          NUM_SCRATCH = 4
) (
  input logic    clock,
  input logic    reset_n,
  sysid_if.slave bus
);

  localparam int SCR_ALLOC = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
  localparam int SHADOW_W  = CNT_W - 32;

  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("sysid_info_regs: CNT_W outside legal range");
  end
  if (NUM_SCRATCH < NUM_SCRATCH_MIN || NUM_SCRATCH > NUM_SCRATCH_MAX) begin : g_bad_num_scratch
    $error("sysid_info_regs: NUM_SCRATCH outside legal range");
  end

  logic                wr_en;
  logic                rd_en;
  logic [2:0]          scr_idx;
  logic                scr_hit;
  logic                ctrl_wr;
  logic                clear;
  logic                status_w1c;
  logic                freeze_q;
  logic                wrapped_q;
  logic [SHADOW_W-1:0] shadow_q;
  logic [31:0]         scratch_q [SCR_ALLOC];
  logic [31:0]         rd_mux;
  logic [31:0]         readdata_q;
  logic                rvalid_q;
  logic [CNT_W-1:0]    count;
  logic                wrap_pulse;

  // A read strobed together with a write is dropped; only the write happens.
  assign wr_en      = bus.write;
  assign rd_en      = bus.read & ~bus.write;
  assign scr_idx    = bus.address[2:0];
  assign scr_hit    = bus.address[3] && (int'(scr_idx) < NUM_SCRATCH);
  assign ctrl_wr    = wr_en && (bus.address == ADDR_CTRL) && bus.byteenable[0];
  assign clear      = ctrl_wr && bus.writedata[CTRL_CLEAR_BIT];
  assign status_w1c = wr_en && (bus.address == ADDR_STATUS) && bus.byteenable[0]
                      && bus.writedata[STATUS_WRAPPED_BIT];

  sysid_uptime_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .freeze     (freeze_q),
    .clear      (clear),
    .count      (count),
    .wrap_pulse (wrap_pulse)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      freeze_q  <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      if (ctrl_wr) freeze_q <= bus.writedata[CTRL_FREEZE_BIT];
      if (wrap_pulse)      wrapped_q <= 1'b1;
      else if (status_w1c) wrapped_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SCR_ALLOC; i++) scratch_q[i] <= '0;
    end else if (wr_en && scr_hit) begin
      for (int i = 0; i < SCR_ALLOC; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (scr_idx == 3'(i) && bus.byteenable[b])
            scratch_q[i][8*b +: 8] <= bus.writedata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_ID:        rd_mux = SYSTEM_ID;
      ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
      ADDR_UPTIME_LO: rd_mux = count[31:0];
      ADDR_UPTIME_HI: rd_mux = 32'(shadow_q);
      ADDR_CTRL:      rd_mux[CTRL_FREEZE_BIT] = freeze_q;
      ADDR_STATUS:    rd_mux[STATUS_WRAPPED_BIT] = wrapped_q;
      default: begin
        if (scr_hit) begin
          for (int i = 0; i < SCR_ALLOC; i++) begin
            if (scr_idx == 3'(i)) rd_mux = scratch_q[i];
          end
        end
      end
    endcase
  end

  // The shadow takes the same pre-edge count that UPTIME_LO returns, so a
  // LO-then-HI pair is atomic however far apart the reads are.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
      shadow_q   <= '0;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) readdata_q <= rd_mux;
      if (rd_en && bus.address == ADDR_UPTIME_LO) shadow_q <= count[CNT_W-1:32];
    end
  end

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = rvalid_q;

endmodule
